// File: rtl/ssd_scan_mux_if.sv
// Digit-content and pin bundle between game-status glue (master) and the SSD scan controller (slave).
interface ssd_scan_mux_if #(
  parameter int unsigned N_DIGITS = 8
);
  localparam int unsigned CUR_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [5*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   blank_mask;
  logic [N_DIGITS-1:0]   dp_mask;
  logic [N_DIGITS-1:0]   blink_mask;
  logic                  update;
  logic                  update_ack;
  logic                  frame_done;
  logic [CUR_W-1:0]      cur_digit;
  logic [N_DIGITS-1:0]   An;
  logic [7:0]            Cathodes;

  modport master (
    output digits, blank_mask, dp_mask, blink_mask, update,
    input  update_ack, frame_done, cur_digit, An, Cathodes
  );

  modport slave (
    input  digits, blank_mask, dp_mask, blink_mask, update,
    output update_ack, frame_done, cur_digit, An, Cathodes
  );
endinterface

// File: rtl/ssd_scan_mux.sv
// N-digit seven-segment scan controller with frame-synchronised shadow update and anode guard time.
// Optional blink support is built when SSD_BLINK_EN is defined.
module ssd_scan_mux #(
  parameter int unsigned N_DIGITS  = 8,
  parameter int unsigned SCAN_DIV  = 17,
  parameter int unsigned GUARD_CYC = 4,
  parameter int unsigned BLINK_DIV = 26
) (
  input  logic          Clk,
  input  logic          Reset,
  ssd_scan_mux_if.slave bus
);
  localparam int unsigned CUR_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned LAST     = N_DIGITS - 1;
  localparam logic [4:0]  CODE_OFF = 5'b10000;

  // Scan control state
  logic [SCAN_DIV-1:0] presc_q, presc_d;
  logic [CUR_W-1:0]    cur_q, cur_d;
  logic                pending_q, pending_d;
  logic                tick, wrap, load;

  // Shadow (displayed) content
  logic [4:0]          code_q [N_DIGITS];
  logic [N_DIGITS-1:0] blank_q, dp_q;

  // Registered pins and pulses
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [7:0]          cat_q, cat_d;
  logic                ack_q, fd_q;

  logic                guard_ok;
  logic                blink_off;
  logic [4:0]          cur_code;

  // Segment pattern {a,b,c,d,e,f,g}, 0 = segment on
  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    logic [6:0] seg;
    seg = 7'b1111111;
    case (code)
      5'h00: seg = 7'b0000001;
      5'h01: seg = 7'b1001111;
      5'h02: seg = 7'b0010010;
      5'h03: seg = 7'b0000110;
      5'h04: seg = 7'b1001100;
      5'h05: seg = 7'b0100100;
      5'h06: seg = 7'b0100000;
      5'h07: seg = 7'b0001111;
      5'h08: seg = 7'b0000000;
      5'h09: seg = 7'b0000100;
      5'h0A: seg = 7'b0001000;
      5'h0B: seg = 7'b1100000;
      5'h0C: seg = 7'b0110001;
      5'h0D: seg = 7'b1000010;
      5'h0E: seg = 7'b0110000;
      5'h0F: seg = 7'b0111000;
      5'h11: seg = 7'b1000100;
      5'h12: seg = 7'b0000010;
      5'h13: seg = 7'b1110001;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Anodes stay dark for the first GUARD_CYC cycles of each slot
  if (GUARD_CYC == 0) begin : g_no_guard
    assign guard_ok = 1'b1;
  end else begin : g_guard
    assign guard_ok = (presc_q >= SCAN_DIV'(GUARD_CYC));
  end

`ifdef SSD_BLINK_EN
  logic [BLINK_DIV-1:0] blink_cnt_q;
  logic [N_DIGITS-1:0]  blink_sh_q;

  // Free-running blink timebase; shadow blink mask follows the frame-synchronous load
  always_ff @(posedge Clk) begin
    if (Reset) begin
      blink_cnt_q <= '0;
      blink_sh_q  <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_DIV'(1);
      if (load) blink_sh_q <= bus.blink_mask;
    end
  end

  assign blink_off = blink_cnt_q[BLINK_DIV-1] && blink_sh_q[cur_q];
`else
  logic unused_blink;
  assign unused_blink = ^{bus.blink_mask, 1'(BLINK_DIV)};
  assign blink_off    = 1'b0;
`endif

  assign cur_code = code_q[cur_q];

  // Next-state and next-output logic
  always_comb begin
    presc_d   = presc_q + SCAN_DIV'(1);
    cur_d     = cur_q;
    tick      = &presc_q;
    wrap      = tick && (cur_q == CUR_W'(LAST));
    load      = wrap && (pending_q || bus.update);
    pending_d = (pending_q || bus.update) && !load;
    an_d      = '1;
    cat_d     = 8'hFF;

    if (tick) begin
      cur_d = wrap ? '0 : cur_q + CUR_W'(1);
    end

    if (guard_ok) begin
      an_d = ~(N_DIGITS'(1) << cur_q);
    end

    if (!blank_q[cur_q] && !blink_off) begin
      cat_d = {seg_decode(cur_code), ~dp_q[cur_q]};
    end
  end

  // Scan control registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_q   <= '0;
      cur_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      cur_q     <= cur_d;
      pending_q <= pending_d;
    end
  end

  // Shadow registers load only at the frame wrap, so a frame is never torn
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < int'(N_DIGITS); k++) code_q[k] <= CODE_OFF;
      blank_q <= '0;
      dp_q    <= '0;
    end else if (load) begin
      for (int k = 0; k < int'(N_DIGITS); k++) code_q[k] <= bus.digits[5*k +: 5];
      blank_q <= bus.blank_mask;
      dp_q    <= bus.dp_mask;
    end
  end

  // Output pipeline stage
  always_ff @(posedge Clk) begin
    if (Reset) begin
      an_q  <= '1;
      cat_q <= 8'hFF;
      ack_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      cat_q <= cat_d;
      ack_q <= load;
      fd_q  <= wrap;
    end
  end

  assign bus.An         = an_q;
  assign bus.Cathodes   = cat_q;
  assign bus.update_ack = ack_q;
  assign bus.frame_done = fd_q;
  assign bus.cur_digit  = cur_q;
endmodule

// File: tb/tb_ssd_scan_mux.sv
// Bench for ssd_scan_mux: an 8-digit and a 5-digit instance against a time-based reference model.
module tb_ssd_scan_mux;
  localparam int unsigned SD   = 2;
  localparam int unsigned SLOT = 1 << SD;
  localparam int          BD   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] in_digits;
  logic [15:0] in_blank, in_dp, in_blink;
  logic        in_update;

  int checks   = 0;
  int failures = 0;

  ssd_scan_mux_if #(.N_DIGITS(8)) bus8 ();
  ssd_scan_mux_if #(.N_DIGITS(5)) bus5 ();

  assign bus8.digits     = in_digits[39:0];
  assign bus8.blank_mask = in_blank[7:0];
  assign bus8.dp_mask    = in_dp[7:0];
  assign bus8.blink_mask = in_blink[7:0];
  assign bus8.update     = in_update;
  assign bus5.digits     = in_digits[24:0];
  assign bus5.blank_mask = in_blank[4:0];
  assign bus5.dp_mask    = in_dp[4:0];
  assign bus5.blink_mask = in_blink[4:0];
  assign bus5.update     = in_update;

  ssd_scan_mux #(.N_DIGITS(8), .SCAN_DIV(SD), .GUARD_CYC(1), .BLINK_DIV(BD)) dut8 (
    .Clk(clk), .Reset(rst), .bus(bus8));
  ssd_scan_mux #(.N_DIGITS(5), .SCAN_DIV(SD), .GUARD_CYC(0), .BLINK_DIV(BD)) dut5 (
    .Clk(clk), .Reset(rst), .bus(bus5));

  always #5 clk = ~clk;

  // Reference model: time since reset decides slot/phase; content is what was captured at the last wrap
  int          m_n [2] = '{8, 5};
  int          m_g [2] = '{1, 0};
  int          m_e [2];
  bit          m_pend [2];
  logic [4:0]  m_code [2][16];
  bit          m_blank [2][16];
  bit          m_dp [2][16];
  bit          m_blink [2][16];
  logic [15:0] x_an [2];
  logic [7:0]  x_cat [2];
  bit          x_fd [2];
  bit          x_ack [2];
  int          x_cur [2];

  function automatic logic [6:0] ref_seg(input logic [4:0] c);
    case (c)
      5'h00: return 7'b0000001;  5'h01: return 7'b1001111;
      5'h02: return 7'b0010010;  5'h03: return 7'b0000110;
      5'h04: return 7'b1001100;  5'h05: return 7'b0100100;
      5'h06: return 7'b0100000;  5'h07: return 7'b0001111;
      5'h08: return 7'b0000000;  5'h09: return 7'b0000100;
      5'h0A: return 7'b0001000;  5'h0B: return 7'b1100000;
      5'h0C: return 7'b0110001;  5'h0D: return 7'b1000010;
      5'h0E: return 7'b0110000;  5'h0F: return 7'b0111000;
      5'h11: return 7'b1000100;  5'h12: return 7'b0000010;
      5'h13: return 7'b1110001;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_e[i] = 0;  m_pend[i] = 0;
        for (int k = 0; k < 16; k++) begin
          m_code[i][k] = 5'h10; m_blank[i][k] = 0; m_dp[i][k] = 0; m_blink[i][k] = 0;
        end
        x_an[i] = '1; x_cat[i] = 8'hFF; x_fd[i] = 0; x_ack[i] = 0; x_cur[i] = 0;
      end else begin
        int  slot, ph;
        bit  blink_now, wrap, load;
        slot = (m_e[i] / SLOT) % m_n[i];
        ph   = m_e[i] % SLOT;
        blink_now = 0;
`ifdef SSD_BLINK_EN
        blink_now = ((m_e[i] % (1 << BD)) >= (1 << (BD - 1))) && m_blink[i][slot];
`endif
        x_an[i] = '1;
        if (ph >= m_g[i]) x_an[i][slot] = 1'b0;
        if (m_blank[i][slot] || blink_now) x_cat[i] = 8'hFF;
        else x_cat[i] = {ref_seg(m_code[i][slot]), ~m_dp[i][slot]};
        wrap = (ph == SLOT - 1) && (slot == m_n[i] - 1);
        load = wrap && (m_pend[i] || in_update);
        x_fd[i]  = wrap;
        x_ack[i] = load;
        if (load) begin
          for (int k = 0; k < m_n[i]; k++) begin
            m_code[i][k]  = in_digits[5*k +: 5];
            m_blank[i][k] = in_blank[k];
            m_dp[i][k]    = in_dp[k];
            m_blink[i][k] = in_blink[k];
          end
        end
        m_pend[i] = (m_pend[i] || in_update) && !load;
        m_e[i]++;
        x_cur[i] = (m_e[i] / SLOT) % m_n[i];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("an8",   32'(bus8.An),         32'(x_an[0][7:0]));
    chk("cat8",  32'(bus8.Cathodes),   32'(x_cat[0]));
    chk("fd8",   32'(bus8.frame_done), 32'(x_fd[0]));
    chk("ack8",  32'(bus8.update_ack), 32'(x_ack[0]));
    chk("cur8",  32'(bus8.cur_digit),  32'(x_cur[0]));
    chk("an5",   32'(bus5.An),         32'(x_an[1][4:0]));
    chk("cat5",  32'(bus5.Cathodes),   32'(x_cat[1]));
    chk("fd5",   32'(bus5.frame_done), 32'(x_fd[1]));
    chk("ack5",  32'(bus5.update_ack), 32'(x_ack[1]));
    chk("cur5",  32'(bus5.cur_digit),  32'(x_cur[1]));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!x_ack[0] && n < 80) begin step(); n++; end
    chk(tag, 32'(n < 80), 32'd1);
  endtask

  task automatic wait_digit(input int k, input string tag);
    int n = 0;
    while (x_an[0][k] !== 1'b0 && n < 80) begin step(); n++; end
    chk(tag, 32'(n < 80), 32'd1);
  endtask

  task automatic request_update();
    in_update = 1'b1;
    step();
    in_update = 1'b0;
  endtask

  initial begin
    int n;
    in_update = 1'b0;
    in_blank  = '0;
    in_dp     = '0;
    in_blink  = '0;
    for (int k = 0; k < 16; k++) in_digits[5*k +: 5] = 5'h10;

    // Reset held three cycles
    rst = 1'b1;
    repeat (3) step();
    chk("rst_an",  32'(bus8.An),         32'hFF);
    chk("rst_cat", 32'(bus8.Cathodes),   32'hFF);
    chk("rst_cur", 32'(bus8.cur_digit),  32'd0);
    chk("rst_fd",  32'(bus8.frame_done), 32'd0);
    chk("rst_ack", 32'(bus8.update_ack), 32'd0);
    rst = 1'b0;

    // Deferred update: new digit0 content only after the wrap
    in_digits[4:0] = 5'h03;
    in_dp          = 16'h0001;
    request_update();
    wait_ack("tmo_ack1");
    wait_digit(0, "tmo_d0a");
    chk("d0_pre", 32'(bus8.Cathodes), 32'b00001100);
    in_digits[4:0] = 5'h08;
    request_update();
    n = 0;
    while (!x_fd[0] && n < 64) begin
      if (x_an[0][0] === 1'b0) chk("d0_hold", 32'(bus8.Cathodes), 32'b00001100);
      step();
      n++;
    end
    chk("tmo_wrap", 32'(n < 64), 32'd1);
    chk("ack_at_wrap", 32'(bus8.update_ack), 32'd1);
    wait_digit(0, "tmo_d0b");
    chk("d0_new", 32'(bus8.Cathodes), 32'b00000000);

    // Special codes
    in_digits[4:0]   = 5'h11;
    in_digits[9:5]   = 5'h13;
    in_digits[14:10] = 5'h15;
    in_digits[19:15] = 5'h12;
    in_dp            = 16'h0003;
    request_update();
    wait_ack("tmo_ack2");
    wait_digit(0, "tmo_y");
    chk("code_Y", 32'(bus8.Cathodes), 32'b10001000);
    wait_digit(1, "tmo_l");
    chk("code_L", 32'(bus8.Cathodes), 32'b11100010);
    wait_digit(2, "tmo_off");
    chk("code_off", 32'(bus8.Cathodes), 32'hFF);

    // Decimal point and blank masks
    in_digits[9:5]   = 5'h07;
    in_digits[14:10] = 5'h02;
    in_dp            = 16'h0004;
    in_blank         = 16'h0002;
    request_update();
    wait_ack("tmo_ack3");
    wait_digit(1, "tmo_blank");
    chk("blank1", 32'(bus8.Cathodes), 32'hFF);
    wait_digit(2, "tmo_dp");
    chk("dp2", 32'(bus8.Cathodes), 32'b00100100);

    // Blink on digit 0 (model-checked; inert without SSD_BLINK_EN)
    in_digits[4:0] = 5'h01;
    in_dp          = 16'h0001;
    in_blank       = '0;
    in_blink       = 16'h0001;
    request_update();
    repeat (96) step();

    // Randomised traffic with occasional mid-frame reset
    for (int it = 0; it < 2500; it++) begin
      in_update = ($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) in_digits = {16'($urandom), $urandom, $urandom};
      if ($urandom_range(7) == 0) in_blank  = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(7) == 0) in_dp     = 16'($urandom);
      if ($urandom_range(7) == 0) in_blink  = 16'($urandom);
      rst = ($urandom_range(299) == 0);
      step();
    end
    rst       = 1'b0;
    in_update = 1'b0;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ssd_scan_mux.md
Name: ssd_scan_mux

Overview:
- Parametrised N-digit seven-segment scan controller for the Nexys-class SSD bank.
- Generalises the hard-wired 8-digit scan/decode in the game top to any digit count and scan rate.
- Adds tear-free frame-synchronised content update, per-digit blank and decimal-point masks, anti-ghosting guard time and optional blink.
- Sits between game-status glue logic (digit codes) and the An/Ca..Cg/Dp pins.

Parameters:
- N_DIGITS, 8, number of digits scanned (1..16).
- SCAN_DIV, 17, prescaler width; the digit advances every 2^SCAN_DIV Clk cycles.
- GUARD_CYC, 4, cycles at the start of each digit slot with all anodes off; must be < 2^SCAN_DIV.
- BLINK_DIV, 26, blink counter width; used only with SSD_BLINK_EN.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- digits  in  5*N_DIGITS  digit codes; digit k is bits [5k+4:5k].
- blank_mask  in  N_DIGITS  1 = digit forced OFF, Dp included.
- dp_mask  in  N_DIGITS  1 = Dp lit on that digit.
- blink_mask  in  N_DIGITS  1 = digit blinks; only used with SSD_BLINK_EN.
- update  in  1  request to capture digits and all masks into the shadow registers.
- update_ack  out  1  one-cycle pulse in the cycle the shadow registers load.
- frame_done  out  1  one-cycle pulse as the index wraps from N_DIGITS-1 to 0.
- cur_digit  out  clog2(N_DIGITS) (min 1)  index of the digit now being driven.
- An  out  N_DIGITS  anodes, active low.
- Cathodes  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active low.

Behaviour:
- Single clock domain, Clk. Reset is synchronous and active-high.
- Reset values:
  - prescaler = 0, cur_digit = 0, pending = 0.
  - Shadow codes = 5'b10000 (OFF); shadow masks = 0.
  - An = all 1s, Cathodes = 8'hFF, update_ack = 0, frame_done = 0.
- Prescaler: free-running SCAN_DIV-bit counter. tick = (prescaler == all 1s).
- Index: on tick, cur_digit increments. At N_DIGITS-1 it wraps to 0 (also for non-power-of-2 N_DIGITS) and frame_done pulses in that cycle.
- Update handshake:
  - update sets pending. update is a level or pulse; repeats while pending are absorbed.
  - Shadow registers load when pending is set (or update is high) in a cycle with frame_done. In that cycle update_ack pulses and pending clears.
  - digits is sampled in the load cycle, not in the request cycle.
  - Display content never changes mid-frame.
- Output pipeline:
  - An and Cathodes are registered, one cycle after cur_digit/prescaler.
  - Active anode: An[cur_digit] = 0 only when prescaler >= GUARD_CYC; otherwise all 1s.
  - GUARD_CYC = 0 disables the guard.
- Decode (abcdefg, 0 = segment on):
  - 0-F: standard hex.
  - 10000: OFF.
  - 10001: Y.
  - 10010: lowercase a.
  - 10011: L.
  - 10100-11111: OFF (defined, never X).
- Dp = ~dp_mask[cur]. blank_mask[cur] = 1 forces Cathodes = 8'hFF.
- Reset mid-frame: everything returns to reset values next cycle. Pending requests are discarded.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SSD_BLINK_EN.
- Defined:
  - BLINK_DIV-bit counter, cleared by Reset.
  - While its MSB = 1, any digit with shadow blink_mask = 1 outputs Cathodes = 8'hFF. Its anode still scans.
  - blink_mask is captured with the other shadow registers.
- Undefined: no blink counter is built; blink_mask is ignored.

Test Plan:
- Reset: N_DIGITS=8, SCAN_DIV=2, GUARD_CYC=1; Reset high 3 cycles -> An=8'hFF, Cathodes=8'hFF, cur_digit=0, no pulses.
- Scan order: SCAN_DIV=2, GUARD_CYC=1.
  - Each digit slot lasts 4 cycles.
  - An[k] is low for 3 of the 4 cycles of slot k, with one cycle all-1s guard.
  - frame_done pulses once every 32 cycles, on the 7->0 wrap.
- Deferred update:
  - Load digit0=5'h3. Mid-frame, update pulse with digit0=5'h8.
  - Required: Cathodes keep 8'b00001100 until the wrap; update_ack coincides with frame_done.
  - Next frame digit0 shows 8'b00000000.
- Codes and masks:
  - Digit codes 10001, 10011, 10101 -> 8'b10001000, 8'b11100010, 8'hFF.
  - dp_mask[2]=1 with code 5'h2 -> 8'b00100100.
  - blank_mask[1]=1 -> 8'hFF on digit 1.
- Non-power-of-2: N_DIGITS=5 -> cur_digit sequence 0,1,2,3,4,0; An width 5; frame_done every 5 ticks.
- Blink (SSD_BLINK_EN, BLINK_DIV=4): blink_mask[0]=1, digit0=5'h1 -> 8'b10011110 while blink MSB=0 and 8'hFF while MSB=1, alternating every 8 cycles. Digits 1-7 unaffected.
